// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serial 5-bit pattern detector fed by a byte stream, with match counter and irq hold
module seq_detect_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [4:0] cfg_pattern,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_threshold,
    input  logic       start,
    input  logic       stop,
    input  logic       irq_clr,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       seq_detected,
    output logic [7:0] match_count,
    output logic       irq,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;
    logic       overlap_q, overlap_d;
    logic [7:0] thresh_q, thresh_d;
    logic [4:0] hist_q, hist_d;
    logic [2:0] len_q, len_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] count_q, count_d;
    logic       seq_q, seq_d;

    logic [4:0] hist_sh;
    logic [2:0] len_sh;
    logic       hit;
    logic [7:0] count_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= 5'b10011;
            overlap_q <= 1'b1;
            thresh_q  <= 8'd0;
            hist_q    <= 5'd0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
            byte_q    <= 8'd0;
            count_q   <= 8'd0;
            seq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            overlap_q <= overlap_d;
            thresh_q  <= thresh_d;
            hist_q    <= hist_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
        end
    end

    // Candidate shift result; only committed while in SHIFT without stop.
    always_comb begin
        hist_sh   = {hist_q[3:0], byte_q[idx_q]};
        len_sh    = (len_q == 3'd5) ? 3'd5 : len_q + 3'd1;
        hit       = (len_sh == 3'd5) && (hist_sh == pat_q);
        count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        overlap_d = overlap_q;
        thresh_d  = thresh_q;
        hist_d    = hist_q;
        len_d     = len_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        count_d   = count_q;
        seq_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d     = cfg_pattern;
                    overlap_d = cfg_overlap;
                    thresh_d  = cfg_threshold;
                end
                if (start && !stop) begin
                    state_d = ARMED;
                    hist_d  = 5'd0;
                    len_d   = 3'd0;
                    idx_d   = 3'd0;
                    count_d = 8'd0;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (byte_valid) begin
                    byte_d  = byte_data;
                    idx_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    hist_d = hist_sh;
                    len_d  = (hit && !overlap_q) ? 3'd0 : len_sh;
                    idx_d  = (idx_q == 3'd0) ? 3'd0 : idx_q - 3'd1;
                    if (hit) begin
                        seq_d   = 1'b1;
                        count_d = count_inc;
                    end
                    // Threshold hit abandons the rest of the byte.
                    if (hit && (thresh_q != 8'd0) && (count_inc == thresh_q))
                        state_d = HOLD;
                    else if (idx_q == 3'd0)
                        state_d = ARMED;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (irq_clr) begin
                    state_d = ARMED;
                    count_d = 8'd0;
                    len_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready   = (state_q == ARMED);
    assign irq          = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign seq_detected = seq_q;
    assign match_count  = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed-vector bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic       cfg_overlap;
    logic [7:0] cfg_threshold;
    logic       start;
    logic       stop;
    logic       irq_clr;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       seq_detected;
    logic [7:0] match_count;
    logic       irq;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] pulses;

    seq_detect_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_overlap   (cfg_overlap),
        .cfg_threshold (cfg_threshold),
        .start         (start),
        .stop          (stop),
        .irq_clr       (irq_clr),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .seq_detected  (seq_detected),
        .match_count   (match_count),
        .irq           (irq),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [4:0] p, input logic ov, input logic [7:0] th);
        cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = ov; cfg_threshold = th;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic accept(input logic [7:0] b);
        byte_valid = 1'b1; byte_data = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // pulses[k-1] holds seq_detected as seen after the k-th shift edge.
    task automatic shifts(input int n, output logic [7:0] p);
        p = 8'd0;
        for (int k = 0; k < n; k++) begin
            tick();
            p[k] = seq_detected;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] p);
        accept(b);
        shifts(8, p);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = 5'd0; cfg_overlap = 1'b0;
        cfg_threshold = 8'd0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        byte_valid = 1'b0; byte_data = 8'd0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_irq", irq, 0);
        check("rst_seq", seq_detected, 0);
        check("rst_count", match_count, 0);
        reset = 1'b0;

        // Default pattern 10011, byte 0x9B matches on the 5th shift.
        do_start();
        check("armed_ready", byte_ready, 1);
        check("armed_busy", busy, 1);
        accept(8'h9B);
        check("shift_ready", byte_ready, 0);
        shifts(8, pulses);
        check("9b_pulses", pulses, 8'h10);
        check("9b_count", match_count, 1);
        check("9b_back_armed", byte_ready, 1);

        // Config write outside IDLE is ignored; history carries over.
        configure(5'b00000, 1'b1, 8'd1);
        send_byte(8'h9B, pulses);
        check("cfgarmed_pulses", pulses, 8'h10);
        check("cfgarmed_count", match_count, 2);
        check("cfgarmed_irq", irq, 0);

        do_stop();
        check("stop_busy", busy, 0);
        check("stop_count_kept", match_count, 2);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_idle", busy, 0);

        // Pattern 10101 with overlap on 0xAA.
        configure(5'b10101, 1'b1, 8'd0);
        do_start();
        check("start_clr_count", match_count, 0);
        send_byte(8'hAA, pulses);
        check("ov_pulses", pulses, 8'h50);
        check("ov_count", match_count, 2);
        do_stop();

        configure(5'b10101, 1'b0, 8'd0);
        do_start();
        send_byte(8'hAA, pulses);
        check("nov_pulses", pulses, 8'h10);
        check("nov_count", match_count, 1);
        do_stop();

        // Threshold 2 stops the byte after bit 7; the 8th shift never happens.
        configure(5'b10101, 1'b1, 8'd2);
        do_start();
        send_byte(8'hAA, pulses);
        check("thr_pulses", pulses, 8'h50);
        check("thr_irq", irq, 1);
        check("thr_ready", byte_ready, 0);
        check("thr_busy", busy, 1);
        check("thr_count", match_count, 2);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("clr_irq", irq, 0);
        check("clr_ready", byte_ready, 1);
        check("clr_count", match_count, 0);
        do_stop();

        // Match spanning a byte boundary: stream ...0001 0011 -> hit on 4th bit of 2nd byte.
        configure(5'b10011, 1'b1, 8'd0);
        do_start();
        send_byte(8'h01, pulses);
        check("span_b1_pulses", pulses, 8'h00);
        send_byte(8'h38, pulses);
        check("span_b2_pulses", pulses, 8'h08);
        check("span_count", match_count, 1);

        // Stop on the edge that would have produced the 5th-shift match.
        accept(8'h9B);
        shifts(4, pulses);
        check("stop_pre_pulses", pulses, 8'h00);
        do_stop();
        check("stop_no_pulse", seq_detected, 0);
        check("stop_mid_busy", busy, 0);
        check("stop_mid_count", match_count, 1);

        // Reset mid-SHIFT restores defaults.
        configure(5'b11111, 1'b0, 8'd1);
        do_start();
        send_byte(8'hFF, pulses);
        check("pre_rst_irq", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        accept(8'h9B);
        shifts(2, pulses);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_seq", seq_detected, 0);
        check("midrst_count", match_count, 0);
        check("midrst_ready", byte_ready, 0);
        do_start();
        send_byte(8'h9B, pulses);
        check("postrst_pulses", pulses, 8'h10);
        check("postrst_count", match_count, 1);
        check("postrst_no_hold", irq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
